jelly_wishbone_arbiter_rr: RTL

//  Round-robin arbiter sharing one Wishbone classic slave (the wishbone-to-AXI4-Lite

---
 rtl/jelly_wishbone_arbiter_rr_if.sv | 40 ++++
 rtl/jelly_wishbone_arbiter_rr.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/jelly_wishbone_arbiter_rr_if.sv
// Bus bundle between NUM Wishbone classic masters, the round-robin arbiter and the bridge slave.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface jelly_wishbone_arbiter_rr_if #(
    parameter int NUM          = 2,
    parameter int WB_ADR_WIDTH = 37,
    parameter int WB_DAT_SIZE  = 3
);
    localparam int WB_DAT_WIDTH = 8 << WB_DAT_SIZE;
    localparam int WB_SEL_WIDTH = 1 << WB_DAT_SIZE;

    logic [NUM*WB_ADR_WIDTH-1:0] s_wb_adr_i;
    logic [NUM*WB_DAT_WIDTH-1:0] s_wb_dat_i;
    logic [NUM*WB_SEL_WIDTH-1:0] s_wb_sel_i;
    logic [NUM-1:0]              s_wb_we_i;
    logic [NUM-1:0]              s_wb_stb_i;
    logic [WB_DAT_WIDTH-1:0]     s_wb_dat_o;
    logic [NUM-1:0]              s_wb_ack_o;

    logic [WB_ADR_WIDTH-1:0]     m_wb_adr_o;
    logic [WB_DAT_WIDTH-1:0]     m_wb_dat_o;
    logic [WB_SEL_WIDTH-1:0]     m_wb_sel_o;
    logic                        m_wb_we_o;
    logic                        m_wb_stb_o;
    logic [WB_DAT_WIDTH-1:0]     m_wb_dat_i;
    logic                        m_wb_ack_i;

    modport slave (
        input  s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_stb_i,
        output s_wb_dat_o, s_wb_ack_o,
        output m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_stb_o,
        input  m_wb_dat_i, m_wb_ack_i
    );

    modport master (
        output s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_stb_i,
        input  s_wb_dat_o, s_wb_ack_o,
        input  m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_stb_o,
        output m_wb_dat_i, m_wb_ack_i
    );
endinterface

// File: rtl/jelly_wishbone_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone classic slave among NUM masters, one transaction at a time.
// Define JELLY_WB_ARB_TIMEOUT_EN to add the ack timeout (TIMEOUT cycles) and sticky timeout_err.
module jelly_wishbone_arbiter_rr #(
    parameter int NUM          = 2,
    parameter int WB_ADR_WIDTH = 37,
    parameter int WB_DAT_SIZE  = 3,
    parameter int TIMEOUT      = 1023
) (
    input  logic                      s_wb_clk_i,
    input  logic                      s_wb_rst_i,
    jelly_wishbone_arbiter_rr_if.slave bus,
    output logic [NUM-1:0]            grant,
    output logic                      timeout_err
);
    localparam int WB_DAT_WIDTH = 8 << WB_DAT_SIZE;
    localparam int WB_SEL_WIDTH = 1 << WB_DAT_SIZE;
    localparam int IDX_W        = $clog2(NUM);
    localparam logic [IDX_W:0] NUM_X = (IDX_W + 1)'(NUM);

    if (NUM < 2 || NUM > 16 || TIMEOUT < 2) begin : g_param_check
        $error("jelly_wishbone_arbiter_rr: unsupported NUM or TIMEOUT");
    end

    // state | meaning
    // IDLE  | no owner; arbitrate among pending strobes (also the one-cycle bubble)
    // BUSY  | grant_q owns the bridge until ack, owner strobe drop or timeout
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           state_q, state_d;
    logic [NUM-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic             owner_stb;
    logic             tmo_fire;

    logic [WB_ADR_WIDTH-1:0] m_adr;
    logic [WB_DAT_WIDTH-1:0] m_dat;
    logic [WB_SEL_WIDTH-1:0] m_sel;
    logic                    m_we;

    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM-1:0] req, input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] sel;
        logic [IDX_W:0]   idx;
        logic             found;
        sel   = last;
        found = 1'b0;
        for (int k = 1; k <= NUM; k++) begin
            idx = {1'b0, last} + (IDX_W + 1)'(k);
            if (idx >= NUM_X) idx = idx - NUM_X;
            if (!found && req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[IDX_W-1:0];
            end
        end
        return sel;
    endfunction

    // Bridge-side muxes follow the registered grant so they are glitch-free and zero when idle.
    always_comb begin
        owner_stb = |(grant_q & bus.s_wb_stb_i);
        m_adr     = '0;
        m_dat     = '0;
        m_sel     = '0;
        m_we      = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (grant_q[i]) begin
                m_adr |= bus.s_wb_adr_i[i*WB_ADR_WIDTH +: WB_ADR_WIDTH];
                m_dat |= bus.s_wb_dat_i[i*WB_DAT_WIDTH +: WB_DAT_WIDTH];
                m_sel |= bus.s_wb_sel_i[i*WB_SEL_WIDTH +: WB_SEL_WIDTH];
                m_we  |= bus.s_wb_we_i[i];
            end
        end
    end

    assign bus.m_wb_adr_o = m_adr;
    assign bus.m_wb_dat_o = m_dat;
    assign bus.m_wb_sel_o = m_sel;
    assign bus.m_wb_we_o  = m_we;
    assign bus.m_wb_stb_o = owner_stb & ~tmo_fire;
    assign bus.s_wb_ack_o = grant_q & {NUM{bus.m_wb_ack_i | tmo_fire}};
    assign bus.s_wb_dat_o = tmo_fire ? {WB_DAT_WIDTH{1'b1}} : bus.m_wb_dat_i;
    assign grant          = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.s_wb_stb_i) begin
                    owner_d = rr_pick(bus.s_wb_stb_i, last_q);
                    grant_d = NUM'(1) << owner_d;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.m_wb_ack_i || !owner_stb || tmo_fire) begin
                    grant_d = '0;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_wb_clk_i or posedge s_wb_rst_i) begin
        if (s_wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef JELLY_WB_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    // Down-counter preloaded while idle so the first BUSY cycle sees TIMEOUT-1; fires at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = CNT_W'(TIMEOUT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign tmo_fire    = (state_q == ST_BUSY) && owner_stb && !bus.m_wb_ack_i && (cnt_q == '0);
    assign timeout_err = err_q;

    always_ff @(posedge s_wb_clk_i or posedge s_wb_rst_i) begin
        if (s_wb_rst_i) begin
            cnt_q <= CNT_W'(TIMEOUT - 1);
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (tmo_fire) err_q <= 1'b1;
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
